// File: rtl/mips_cpu_core.sv
// Single-cycle 32-bit MIPS integer core: PC, 32x32 register file, ALU and decode.
// Instruction and data memories are external; all outputs are combinational from PC, GPRs and Instruction.
module mips_cpu_core #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Instruction,
  input  logic [31:0] DataToWd,
  output logic [31:0] ALU_result,
  output logic [31:0] Ext_Imm,
  output logic [31:0] addr,
  output logic [31:0] Out1,
  output logic [31:0] Out2,
  output logic        MemWrite,
  output logic        MemtoReg
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03, OP_BEQ  = 6'h04,
    OP_BNE   = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
    OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI = 6'h0E,
    OP_LUI   = 6'h0F, OP_LW    = 6'h23, OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_JR   = 6'h08,
    FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23,
    FN_AND = 6'h24, FN_OR  = 6'h25, FN_XOR = 6'h26, FN_NOR  = 6'h27,
    FN_SLT = 6'h2A, FN_SLTU = 6'h2B
  } funct_e;

  logic [31:0] r_pc;
  logic [31:0] r_gpr [32];

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [15:0] w_imm;
  logic [25:0] w_target;
  logic [31:0] w_pc4, w_rs_val, w_rt_val, w_ext, w_alu;
  logic [31:0] w_wr_data, w_next_pc;
  logic [4:0]  w_wr_idx;
  logic        w_wr_en, w_mem_wr, w_mem_to_reg;

  assign w_op     = Instruction[31:26];
  assign w_rs     = Instruction[25:21];
  assign w_rt     = Instruction[20:16];
  assign w_rd     = Instruction[15:11];
  assign w_shamt  = Instruction[10:6];
  assign w_funct  = Instruction[5:0];
  assign w_imm    = Instruction[15:0];
  assign w_target = Instruction[25:0];

  assign w_pc4    = r_pc + 32'd4;
  assign w_rs_val = (w_rs == 5'd0) ? '0 : r_gpr[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? '0 : r_gpr[w_rt];

  // Only the logical immediates are zero-extended; sltiu compares against the sign-extended value.
  assign w_ext = (w_op == OP_ANDI || w_op == OP_ORI || w_op == OP_XORI)
               ? {16'h0000, w_imm} : {{16{w_imm[15]}}, w_imm};

  always_comb begin
    w_alu        = '0;
    w_wr_en      = 1'b0;
    w_wr_idx     = w_rt;
    w_mem_wr     = 1'b0;
    w_mem_to_reg = 1'b0;
    w_next_pc    = w_pc4;
    case (w_op)
      OP_RTYPE: begin
        w_wr_idx = w_rd;
        w_wr_en  = 1'b1;
        case (w_funct)
          FN_ADD, FN_ADDU: w_alu = w_rs_val + w_rt_val;
          FN_SUB, FN_SUBU: w_alu = w_rs_val - w_rt_val;
          FN_AND:  w_alu = w_rs_val & w_rt_val;
          FN_OR:   w_alu = w_rs_val | w_rt_val;
          FN_XOR:  w_alu = w_rs_val ^ w_rt_val;
          FN_NOR:  w_alu = ~(w_rs_val | w_rt_val);
          FN_SLT:  w_alu = {31'b0, $signed(w_rs_val) < $signed(w_rt_val)};
          FN_SLTU: w_alu = {31'b0, w_rs_val < w_rt_val};
          FN_SLL:  w_alu = w_rt_val << w_shamt;
          FN_SRL:  w_alu = w_rt_val >> w_shamt;
          FN_SRA:  w_alu = $unsigned($signed(w_rt_val) >>> w_shamt);
          FN_JR: begin
            w_wr_en   = 1'b0;
            w_next_pc = w_rs_val;
          end
          default: w_wr_en = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin w_alu = w_rs_val + w_ext; w_wr_en = 1'b1; end
      OP_SLTI:  begin w_alu = {31'b0, $signed(w_rs_val) < $signed(w_ext)}; w_wr_en = 1'b1; end
      OP_SLTIU: begin w_alu = {31'b0, w_rs_val < w_ext}; w_wr_en = 1'b1; end
      OP_ANDI:  begin w_alu = w_rs_val & w_ext; w_wr_en = 1'b1; end
      OP_ORI:   begin w_alu = w_rs_val | w_ext; w_wr_en = 1'b1; end
      OP_XORI:  begin w_alu = w_rs_val ^ w_ext; w_wr_en = 1'b1; end
      OP_LUI:   begin w_alu = {w_imm, 16'h0000}; w_wr_en = 1'b1; end
      OP_LW: begin
        w_alu        = w_rs_val + w_ext;
        w_wr_en      = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      OP_SW: begin
        w_alu    = w_rs_val + w_ext;
        w_mem_wr = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        w_alu = w_rs_val - w_rt_val;
        if ((w_alu == '0) == (w_op == OP_BEQ))
          w_next_pc = w_pc4 + {w_ext[29:0], 2'b00};
      end
      OP_J: w_next_pc = {w_pc4[31:28], w_target, 2'b00};
      OP_JAL: begin
        w_wr_en   = 1'b1;
        w_wr_idx  = 5'd31;
        w_next_pc = {w_pc4[31:28], w_target, 2'b00};
      end
      default: ;
    endcase
  end

  assign w_wr_data = (w_op == OP_JAL) ? w_pc4 : (w_mem_to_reg ? DataToWd : w_alu);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_pc <= PC_RESET;
      for (int unsigned i = 0; i < 32; i++) r_gpr[i] <= '0;
    end else begin
      r_pc <= w_next_pc;
      if (w_wr_en && w_wr_idx != 5'd0) r_gpr[w_wr_idx] <= w_wr_data;
    end
  end

  assign addr       = r_pc;
  assign Out1       = w_rs_val;
  assign Out2       = w_rt_val;
  assign ALU_result = w_alu;
  assign Ext_Imm    = w_ext;
  assign MemWrite   = w_mem_wr;
  assign MemtoReg   = w_mem_to_reg;

endmodule

// File: tb/tb_mips_cpu_core.sv
// Bench for mips_cpu_core: directed program table, async reset checks, then random
// instructions against an instruction-level reference model. The bench acts as the instruction stream.
module tb_mips_cpu_core;

  logic        Clock, Reset;
  logic [31:0] Instruction, DataToWd;
  logic [31:0] ALU_result, Ext_Imm, addr, Out1, Out2;
  logic        MemWrite, MemtoReg;

  mips_cpu_core #(.PC_RESET(32'h0000_0000)) dut (
    .Clock(Clock), .Reset(Reset), .Instruction(Instruction), .DataToWd(DataToWd),
    .ALU_result(ALU_result), .Ext_Imm(Ext_Imm), .addr(addr), .Out1(Out1), .Out2(Out2),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  typedef struct {
    logic [31:0] instr, din, addr, alu, o1, o2, ext;
    logic        mw, m2r, alu_chk;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] instr, din, a, alu, o1, o2, ext,
                              input logic mw, m2r, alu_chk);
    vec_t v;
    v.instr = instr; v.din = din; v.addr = a; v.alu = alu; v.o1 = o1; v.o2 = o2;
    v.ext = ext; v.mw = mw; v.m2r = m2r; v.alu_chk = alu_chk;
    return v;
  endfunction

  // Reference model: architectural state plus per-instruction semantics.
  logic [31:0] m_gpr [32];
  logic [31:0] m_pc;

  typedef struct {
    logic [31:0] addr, o1, o2, ext, alu, wdata, npc;
    logic [4:0]  widx;
    logic        mw, m2r, alu_ok, wr;
  } exp_t;

  task automatic model_exec(input logic [31:0] ins, input logic [31:0] din, output exp_t e);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] a, b, se, ze, pc4, res;
    logic        known;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    sh = ins[10:6];  fn = ins[5:0];
    a = m_gpr[rs]; b = m_gpr[rt];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0, ins[15:0]};
    pc4 = m_pc + 4;
    e.addr = m_pc; e.o1 = a; e.o2 = b;
    e.ext = (op == 6'h0C || op == 6'h0D || op == 6'h0E) ? ze : se;
    e.alu = 0; e.wdata = 0; e.npc = pc4; e.widx = rt;
    e.mw = 0; e.m2r = 0; e.alu_ok = 0; e.wr = 0;
    res = 0; known = 1;
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: res = a + b;
        6'h22, 6'h23: res = a - b;
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h26: res = a ^ b;
        6'h27: res = ~(a | b);
        6'h2A: res = ($signed(a) < $signed(b)) ? 1 : 0;
        6'h2B: res = (a < b) ? 1 : 0;
        6'h00: res = b << sh;
        6'h02: res = b >> sh;
        6'h03: res = $unsigned($signed(b) >>> sh);
        default: known = 0;
      endcase
      if (fn == 6'h08) e.npc = a;
      else if (known) begin e.alu = res; e.alu_ok = 1; e.wr = 1; e.widx = rd; e.wdata = res; end
    end else begin
      case (op)
        6'h08, 6'h09: res = a + se;
        6'h0A: res = ($signed(a) < $signed(se)) ? 1 : 0;
        6'h0B: res = (a < se) ? 1 : 0;
        6'h0C: res = a & ze;
        6'h0D: res = a | ze;
        6'h0E: res = a ^ ze;
        6'h0F: res = {ins[15:0], 16'h0};
        6'h23, 6'h2B: res = a + se;
        default: known = 0;
      endcase
      if (known) begin
        e.alu = res; e.alu_ok = 1;
        if (op == 6'h2B) e.mw = 1;
        else begin e.wr = 1; e.m2r = (op == 6'h23); e.wdata = (op == 6'h23) ? din : res; end
      end
      if (op == 6'h04 && a == b) e.npc = pc4 + (se << 2);
      if (op == 6'h05 && a != b) e.npc = pc4 + (se << 2);
      if (op == 6'h02 || op == 6'h03) e.npc = {pc4[31:28], ins[25:0], 2'b00};
      if (op == 6'h03) begin e.wr = 1; e.widx = 31; e.wdata = pc4; end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] rfn [15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h01};
    logic [5:0] iop [15] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                             6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F, 6'h10, 6'h08};
    logic [31:0] r;
    int unsigned k;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k < 4) return {6'h00, r[25:6], rfn[$urandom_range(0, 14)]};
    if (k < 9) return {iop[$urandom_range(0, 14)], r[25:0]};
    return {(r[31] ? 6'h03 : 6'h02), r[25:0]};
  endfunction

  vec_t tbl [20];

  initial begin
    exp_t e;
    logic [31:0] ins, din;

    tbl[0]  = mk(enc_i(6'h08, 0, 1, 16'd5),      0, 32'h00, 32'h5,        0, 0, 32'h5, 0, 0, 1);
    tbl[1]  = mk(enc_i(6'h08, 0, 2, 16'hFFFD),   0, 32'h04, 32'hFFFFFFFD, 0, 0, 32'hFFFFFFFD, 0, 0, 1);
    tbl[2]  = mk(enc_r(1, 2, 3, 0, 6'h20),       0, 32'h08, 32'h2, 32'h5, 32'hFFFFFFFD, 32'h1820, 0, 0, 1);
    tbl[3]  = mk(enc_i(6'h0D, 0, 4, 16'h8000),   0, 32'h0C, 32'h8000, 0, 0, 32'h00008000, 0, 0, 1);
    tbl[4]  = mk(enc_i(6'h04, 1, 1, 16'hFFFE),   0, 32'h10, 0, 32'h5, 32'h5, 32'hFFFFFFFE, 0, 0, 0);
    tbl[5]  = mk(enc_i(6'h0F, 0, 5, 16'h1234),   0, 32'h0C, 32'h12340000, 0, 0, 32'h1234, 0, 0, 1);
    tbl[6]  = mk(enc_r(2, 1, 7, 0, 6'h2A),       0, 32'h10, 32'h1, 32'hFFFFFFFD, 32'h5, 32'h382A, 0, 0, 1);
    tbl[7]  = mk(enc_r(2, 1, 8, 0, 6'h2B),       0, 32'h14, 32'h0, 32'hFFFFFFFD, 32'h5, 32'h402B, 0, 0, 1);
    tbl[8]  = mk(enc_i(6'h2B, 0, 3, 16'd8),      0, 32'h18, 32'h8, 0, 32'h2, 32'h8, 1, 0, 1);
    tbl[9]  = mk(enc_i(6'h23, 0, 6, 16'd8), 32'hCAFEBABE, 32'h1C, 32'h8, 0, 0, 32'h8, 0, 1, 1);
    tbl[10] = mk(enc_r(6, 5, 9, 0, 6'h20),       0, 32'h20, 32'hDD32BABE, 32'hCAFEBABE, 32'h12340000, 32'h4820, 0, 0, 1);
    tbl[11] = mk(enc_i(6'h05, 1, 1, 16'd5),      0, 32'h24, 0, 32'h5, 32'h5, 32'h5, 0, 0, 0);
    tbl[12] = mk(enc_j(6'h02, 26'h10),           0, 32'h28, 0, 0, 0, 32'h10, 0, 0, 0);
    tbl[13] = mk(enc_j(6'h03, 26'h20),           0, 32'h40, 0, 0, 0, 32'h20, 0, 0, 0);
    tbl[14] = mk(enc_i(6'h08, 0, 0, 16'd7),      0, 32'h80, 32'h7, 0, 0, 32'h7, 0, 0, 1);
    tbl[15] = mk(enc_r(0, 31, 10, 0, 6'h20),     0, 32'h84, 32'h44, 0, 32'h44, 32'h5020, 0, 0, 1);
    tbl[16] = mk(enc_r(31, 0, 0, 0, 6'h08),      0, 32'h88, 0, 32'h44, 0, 32'h8, 0, 0, 0);
    tbl[17] = mk(enc_i(6'h3F, 0, 1, 16'd1),      0, 32'h44, 0, 0, 32'h5, 32'h1, 0, 0, 0);
    tbl[18] = mk(enc_r(1, 0, 11, 0, 6'h20),      0, 32'h48, 32'h5, 32'h5, 0, 32'h5820, 0, 0, 1);
    tbl[19] = mk(enc_r(0, 0, 0, 0, 6'h00),       0, 32'h4C, 0, 0, 0, 32'h0, 0, 0, 1);

    Reset = 1'b1; Instruction = '0; DataToWd = '0;
    #100;
    chk("reset_addr", addr, 32'h0);
    chk("reset_memwrite", {31'b0, MemWrite}, 32'h0);
    #100;
    @(negedge Clock);
    Reset = 1'b0;

    foreach (tbl[i]) begin
      Instruction = tbl[i].instr;
      DataToWd    = tbl[i].din;
      #1;
      chk($sformatf("v%0d_addr", i), addr, tbl[i].addr);
      chk($sformatf("v%0d_out1", i), Out1, tbl[i].o1);
      chk($sformatf("v%0d_out2", i), Out2, tbl[i].o2);
      chk($sformatf("v%0d_ext", i), Ext_Imm, tbl[i].ext);
      chk($sformatf("v%0d_memwrite", i), {31'b0, MemWrite}, {31'b0, tbl[i].mw});
      chk($sformatf("v%0d_memtoreg", i), {31'b0, MemtoReg}, {31'b0, tbl[i].m2r});
      if (tbl[i].alu_chk) chk($sformatf("v%0d_alu", i), ALU_result, tbl[i].alu);
      @(negedge Clock);
    end

    // Pending write of $1 must be discarded when reset lands between edges.
    Instruction = enc_i(6'h08, 0, 1, 16'h55);
    #2 Reset = 1'b1;
    #1;
    chk("async_reset_addr", addr, 32'h0);
    for (int r = 1; r < 32; r++) begin
      Instruction = enc_r(r[4:0], r[4:0], 0, 0, 6'h20);
      #1;
      chk($sformatf("reset_gpr%0d_out1", r), Out1, 32'h0);
      chk($sformatf("reset_gpr%0d_out2", r), Out2, 32'h0);
    end
    @(negedge Clock);
    Reset = 1'b0;

    for (int r = 0; r < 32; r++) m_gpr[r] = '0;
    m_pc = 32'h0;
    for (int n = 0; n < 400; n++) begin
      ins = rand_instr();
      din = $urandom;
      Instruction = ins;
      DataToWd    = din;
      model_exec(ins, din, e);
      #1;
      chk("rnd_addr", addr, e.addr);
      chk("rnd_out1", Out1, e.o1);
      chk("rnd_out2", Out2, e.o2);
      chk("rnd_ext", Ext_Imm, e.ext);
      chk("rnd_memwrite", {31'b0, MemWrite}, {31'b0, e.mw});
      chk("rnd_memtoreg", {31'b0, MemtoReg}, {31'b0, e.m2r});
      if (e.alu_ok) chk("rnd_alu", ALU_result, e.alu);
      @(posedge Clock);
      if (e.wr && e.widx != 0) m_gpr[e.widx] = e.wdata;
      m_pc = e.npc;
      @(negedge Clock);
    end
    #1;
    chk("rnd_final_addr", addr, m_pc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_cpu_core.md
Name: mips_cpu_core

Overview:
Single-cycle 32-bit MIPS integer core. It contains the PC, 32x32 register file, ALU, main/ALU control and the immediate extender. Instruction memory and data memory are external: the core drives the fetch address `addr`, receives the fetched word on `Instruction`, presents the data-memory address, store data and control, and takes load data back on `DataToWd`.

Parameters:
- PC_RESET, 32'h0000_0000, PC value after reset.

Ports:
- Clock  in  1  System clock; all state updates on the rising edge.
- Reset  in  1  Asynchronous, active-high reset.
- Instruction  in  32  Instruction word at address `addr`; used combinationally within the cycle.
- DataToWd  in  32  Load data returned from data memory for address `ALU_result`.
- ALU_result  out  32  ALU output; also the data-memory address.
- Ext_Imm  out  32  Extended 16-bit immediate of the current instruction.
- addr  out  32  Current PC (byte address; instruction-fetch address).
- Out1  out  32  Register file read port 1 = GPR[rs].
- Out2  out  32  Register file read port 2 = GPR[rt]; also the store data.
- MemWrite  out  1  High during a sw cycle.
- MemtoReg  out  1  High during a lw cycle (write-back selects DataToWd).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports Clock, Reset).
- Reset asserted, asynchronously:
  - PC = PC_RESET.
  - All 32 GPRs = 0.
- While in reset, all outputs are combinational from that state (addr = 0).
- Single-cycle operation: every instruction completes in one clock.
  - Outputs are purely combinational from PC, GPRs and Instruction.
  - Writes to the PC and GPRs occur on the rising Clock edge.
- Register file:
  - Two asynchronous read ports, one synchronous write port.
  - GPR[0] reads 0 always; writes to it are ignored.
  - A read of a register being written in the same cycle returns the old value.
- Decode fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0], target[25:0].
- Supported instructions:
  - R-type (op 0): add 0x20, addu 0x21, sub 0x22, subu 0x23, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A, sltu 0x2B, sll 0x00, srl 0x02, sra 0x03, jr 0x08. Destination rd; sll/srl/sra shift rt by shamt.
  - I-type: addi 0x08, addiu 0x09, slti 0x0A, sltiu 0x0B, andi 0x0C, ori 0x0D, xori 0x0E, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, bne 0x05. Destination rt.
  - J-type: j 0x02, jal 0x03 (jal writes PC+4 to GPR[31]).
- Ext_Imm:
  - Zero-extended for andi/ori/xori.
  - Sign-extended for all other opcodes.
  - lui result = {imm,16'h0}.
- Arithmetic rules:
  - 32-bit wrap-around; no overflow exceptions (add/addi behave as addu/addiu).
  - slt/slti are signed; sltu/sltiu are unsigned and compare against the sign-extended immediate.
- Write-back data = MemtoReg ? DataToWd : ALU_result (jal: PC+4).
- Data-memory signals:
  - lw: `ALU_result` = rs + sext(imm).
  - sw: `MemWrite` = 1, `Out2` = store data, no GPR write.
- Next PC:
  - Default: PC+4.
  - beq taken when rs==rt; bne taken when rs!=rt. Taken branch: PC+4+(sext(imm)<<2).
  - j/jal: {PC+4[31:28], target, 2'b00}.
  - jr: GPR[rs].
- Undefined op/funct: NOP — no GPR write, MemWrite = 0, PC+4.
- Reset asserted mid-instruction: the pending write is discarded and state returns to reset values immediately.
- Deassertion of Reset: the first fetch is at PC_RESET on the next edge sequence.

Test Plan:
1. Hold Reset 200 ns, then release. Required: `addr` = 0 during reset; `addr` = 0, 4, 8 on successive rising edges; `MemWrite` = 0.
2. Execute `addi $1,$0,5`, then `addi $2,$0,-3`, then `add $3,$1,$2`. Required: `Out1`/`Out2` show 5 and 0xFFFFFFFD; `ALU_result` = 2; a later read of $3 = 2. On the second instruction, `Ext_Imm` = 0xFFFFFFFD.
3. Execute `ori $4,$0,0x8000` and `lui $5,0x1234`. Required: `Ext_Imm` = 0x00008000 for the ori; $5 = 0x12340000; `slt` of $2 vs $1 gives 1; `sltu` gives 0.
4. Execute `sw $3,8($0)`. Required: `MemWrite` = 1, `ALU_result` = 8, `Out2` = 2. Then execute `lw $6,8($0)` with `DataToWd` = 0xCAFEBABE. Required: `MemtoReg` = 1 and $6 = 0xCAFEBABE.
5. Branch and jump:
   - At PC 0x10, `beq $1,$1,-2`. Required: next `addr` = 0x0C.
   - `bne $1,$1,…`. Required: next `addr` = PC+4.
   - `j 0x40` (target 0x10). Required: `addr` = 0x40.
   - `jal`. Required: GPR[31] = PC+4.
6. Write-protection and reset:
   - `addi $0,$0,7`. Required: $0 reads 0.
   - Assert Reset asynchronously between edges. Required: `addr` drops to 0 without waiting for a clock edge, and all GPRs read 0.
